// File: rtl/rgb_frame_reader_if.sv
// Bus bundle for rgb_frame_reader: frame-RAM read port plus the outgoing pixel stream.
// With GRAY_OUT_EN defined, the stream also carries an 8-bit luma lane (m_gray).
interface rgb_frame_reader_if;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [31:0] rd_q;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eol;
`ifdef GRAY_OUT_EN
  logic [7:0]  m_gray;
`endif

  // master: the frame reader (drives the RAM address and the pixel stream)
  modport master (
    output rd_addr, rd_en, m_valid, m_data, m_sof, m_eol,
`ifdef GRAY_OUT_EN
    output m_gray,
`endif
    input  rd_q, m_ready
  );

  // slave: the RAM on one side and the downstream pixel consumer on the other
  modport slave (
    input  rd_addr, rd_en, m_valid, m_data, m_sof, m_eol,
`ifdef GRAY_OUT_EN
    input  m_gray,
`endif
    output rd_q, m_ready
  );
endinterface

// File: rtl/rgb_frame_reader.sv
// Reads a ROW x COL RGB frame from the frame RAM and streams it in raster order,
// using a credit-limited prefetch FIFO. Optional GRAY_OUT_EN adds an m_gray luma lane.
module rgb_frame_reader #(
  parameter int ROW        = 250,
  parameter int COL        = 250,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state,
  rgb_frame_reader_if.master bus
);

  localparam int NPIX = ROW * COL;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int XW   = (COL > 1) ? $clog2(COL) : 1;
  localparam int YW   = (ROW > 1) ? $clog2(ROW) : 1;
`ifdef GRAY_OUT_EN
  localparam int EW   = 34;
`else
  localparam int EW   = 26;
`endif

  localparam logic [15:0]   LAST_ADDR = 16'(NPIX - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(COL - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     rd_addr_q, rd_addr_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [RD_LAT-1:0] sr_vld_q, sr_sof_q, sr_eol_q;
  logic [EW-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic            credit_ok;
  logic            issue;
  logic            last_issue;
  logic            issue_sof;
  logic            issue_eol;
  logic            push;
  logic            pop;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head;

  // Credit rule: a read is only issued if the FIFO is guaranteed a free slot when it lands.
  assign credit_ok  = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < {1'b0, DEPTH_C};
  assign issue      = (state_q == S_FETCH) && credit_ok;
  assign last_issue = issue && (rd_addr_q == LAST_ADDR);
  assign issue_sof  = (x_q == '0) && (y_q == '0);
  assign issue_eol  = (x_q == X_LAST);

  assign push = sr_vld_q[RD_LAT-1];
  // Valid/ready: m_valid is FIFO-not-empty only; a transfer (and pop) happens when
  // m_valid & m_ready, and the head entry holds still while m_valid & !m_ready.
  assign pop  = (fifo_cnt_q != '0) && bus.m_ready;

  assign inflight_d = inflight_q + CW'(issue) - CW'(push);
  assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

`ifdef GRAY_OUT_EN
  logic [9:0] gray_sum;
  assign gray_sum = {2'b00, bus.rd_q[23:16]} + {1'b0, bus.rd_q[15:8], 1'b0}
                  + {2'b00, bus.rd_q[7:0]};
  assign wr_entry = {gray_sum[9:2], sr_eol_q[RD_LAT-1], sr_sof_q[RD_LAT-1], bus.rd_q[23:0]};
`else
  assign wr_entry = {sr_eol_q[RD_LAT-1], sr_sof_q[RD_LAT-1], bus.rd_q[23:0]};
`endif

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    x_d       = x_q;
    y_d       = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          rd_addr_d = '0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      S_FETCH: begin
        if (last_issue) begin
          state_d = S_DRAIN;
        end else if (issue) begin
          rd_addr_d = rd_addr_q + 16'd1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final pop empties the FIFO so done lands on the next cycle.
        if ((fifo_cnt_d == '0) && (inflight_d == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      sr_vld_q   <= '0;
      sr_sof_q   <= '0;
      sr_eol_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_q + PW'(push);
      rptr_q     <= rptr_q + PW'(pop);
      sr_vld_q[0] <= issue;
      sr_sof_q[0] <= issue && issue_sof;
      sr_eol_q[0] <= issue && issue_eol;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_sof_q[i] <= sr_sof_q[i-1];
        sr_eol_q[i] <= sr_eol_q[i-1];
      end
    end
  end

  // Storage needs no reset: nothing is visible unless the count says the slot is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= wr_entry;
    end
  end

  assign head = fifo_mem_q[rptr_q];

  assign bus.rd_en   = issue;
  assign bus.rd_addr = rd_addr_q;
  assign bus.m_valid = (fifo_cnt_q != '0);
  assign bus.m_data  = bus.m_valid ? head[23:0] : 24'h000000;
  assign bus.m_sof   = bus.m_valid && head[24];
  assign bus.m_eol   = bus.m_valid && head[25];
`ifdef GRAY_OUT_EN
  assign bus.m_gray  = bus.m_valid ? head[33:26] : 8'h00;
`endif

  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: doc/rgb_frame_reader.md
Name: rgb_frame_reader

Overview:
Reads a decoded RGB frame out of the 32-bit RGB frame RAM, which is filled by the Bayer demosaic block, and streams it in raster order on a valid/ready pixel interface. It is the read-side client of that RAM's rd port and feeds the display/UART/USB downstream path. A small prefetch FIFO hides the RAM read latency and absorbs downstream backpressure without losing or duplicating pixels.

Parameters:
ROW, 250, frame height in lines
COL, 250, frame width in pixels
RD_LAT, 2, RAM read latency in clk cycles from rd_en to valid rd_q; legal values 1 or 2
FIFO_DEPTH, 4, prefetch FIFO entries; power of 2, must be at least RD_LAT+1

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame read
busy  out  1  high while a frame transfer is in progress
done  out  1  one-cycle pulse when the last pixel is accepted
rd_addr  out  16  RAM read address, linear Y*COL+X
rd_en  out  1  RAM read enable
rd_q  in  32  RAM read data {8'h00,R,G,B}
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_data  out  24  {R,G,B}, taken from rd_q[23:0]
m_sof  out  1  qualifies m_data for pixel (0,0)
m_eol  out  1  qualifies m_data for the last pixel of each line (X==COL-1)

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_sof=0, m_eol=0, m_data=0. The FIFO, in-flight counter and X/Y counters are cleared; the state machine goes to IDLE.
- State machine:
  - IDLE: start=1 -> FETCH. rd_addr is cleared to 0 and busy goes to 1 on the next cycle.
  - FETCH: issues reads.
  - DRAIN: all ROW*COL reads are issued; waits for the FIFO to empty.
  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then -> IDLE.
- Read issue: in FETCH, rd_en=1 on a cycle only when fifo_count + inflight < FIFO_DEPTH. rd_addr increments by 1 after each issued read. When address ROW*COL-1 is issued, the next state is DRAIN. rd_en is never asserted outside FETCH.
- In-flight tracking: a RD_LAT-deep shift register of rd_en. At its output, rd_q[23:0] is pushed into the FIFO together with sof/eol tag bits. Tags come from a tag-side X/Y counter pipelined alongside the read.
- FIFO never overflows, by construction of the credit rule. A push to a full FIFO is a design error; the bench asserts that it never happens.
- Output handshake:
  - m_valid = FIFO not empty.
  - A transfer occurs when m_valid & m_ready; on that cycle the FIFO pops.
  - m_data, m_sof and m_eol are stable while m_valid=1 and m_ready=0.
  - m_valid does not depend combinationally on m_ready.
- Throughput: with m_ready held at 1, one pixel per cycle is sustained after the initial RD_LAT+1 cycles of fill latency.
- Transfer order: exactly ROW*COL transfers per frame, in raster order. m_sof is set on the first transfer only. m_eol is set on every transfer where X==COL-1.
- done is pulsed the cycle after the final transfer is accepted.
- start while busy=1 is ignored and has no effect on the frame in progress.
- start in the same cycle as DONE is ignored; the next start is honoured from IDLE.
- reset asserted mid-frame: all outputs go to their reset values immediately. After release the block is in IDLE and sends no partial frame.
- Arithmetic: rd_addr is 16 bits; ROW*COL must be at most 65536. X wraps COL-1 -> 0 and increments Y. The counter is terminal at ROW*COL-1.

Optional Feature:
- Macro: GRAY_OUT_EN.
- Defined: adds output port m_gray[7:0] = (R + 2*G + B) >> 2, computed in 10 bits and truncated.
  - The value is registered and stored in the FIFO with the pixel, so it is aligned and qualified by m_valid.
  - Reset value is 0.
- Undefined: the port does not exist and there is no added logic; all other behaviour is identical.

Test Plan:
- ROW=4, COL=4, RAM preloaded mem[a]=a*0x010101; one start, m_ready=1 -> 16 transfers, m_data=0x000000..0x0F0F0F in order. m_sof on transfer 0 only, m_eol on transfers 3/7/11/15. done pulses once; busy falls with done.
- Same setup, m_ready random 30% high -> identical data sequence, no FIFO overflow, m_data stable during stalls, rd_en never high when fifo_count+inflight==FIFO_DEPTH.
- Default ROW=COL=250, RD_LAT=2, m_ready=1 -> first m_valid no later than 4 cycles after start. 62500 transfers follow in 62500 consecutive cycles. The last rd_addr is 62499.
- start re-pulsed mid-frame at transfer 10 -> ignored; frame completes with 62500 transfers and exactly one done.
- reset low at transfer 100 -> m_valid, busy and rd_en drop at once. After release with no start, no transfers occur; a new start produces a full frame beginning with m_sof at address 0.
- GRAY_OUT_EN defined, pixel 0x00FF8040 -> m_gray = (255+256+64)>>2 = 0x8F; pixel 0x00FFFFFF -> 0xFF.
